// File: rtl/alu_req_responder_if.sv
// Request/response channel between an ALU initiator and the alu_req_responder.
// The master drives operands and response acceptance; the slave drives results.
interface alu_req_responder_if #(
    parameter int WIDTH = 32
);
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic [3:0]       req_select;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_carry;
    logic             rsp_overflow;
    logic             rsp_zero;
    logic             rsp_illegal;

    modport master (
        output req_valid, req_a, req_b, req_select, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_carry, rsp_overflow, rsp_zero, rsp_illegal
    );

    modport slave (
        input  req_valid, req_a, req_b, req_select, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_carry, rsp_overflow, rsp_zero, rsp_illegal
    );
endinterface

// File: rtl/alu_req_responder.sv
// Handshaked ALU: one operation in flight, single-cycle execute except for
// in-range shifts, which iterate SHIFT_STEP bits per cycle.
//
// state | meaning
// IDLE  | ready for a request
// EXEC  | single-cycle compute, result registered on exit
// SHIFT | iterative shift, k bits remaining
// RESP  | response held until rsp_ready
module alu_req_responder #(
    parameter int WIDTH      = 32,
    parameter int SHIFT_STEP = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    alu_req_responder_if.slave  bus,
    output logic                busy
);
    localparam int               KW      = $clog2(WIDTH) + 1;
    localparam logic [KW-1:0]    STEP_K  = KW'(SHIFT_STEP);
    localparam logic [WIDTH-1:0] WIDTH_V = WIDTH'(WIDTH);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0100;
    localparam logic [3:0] OP_XOR  = 4'b0110;
    localparam logic [3:0] OP_SLL  = 4'b1000;
    localparam logic [3:0] OP_SRL  = 4'b1010;
    localparam logic [3:0] OP_SLT  = 4'b1100;
    localparam logic [3:0] OP_SLTU = 4'b1110;

    typedef enum logic [1:0] {IDLE, EXEC, SHIFT, RESP} state_t;

    state_t           state;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [3:0]       op_sel;
    logic [KW-1:0]    k;
    logic             req_ready_q;
    logic             rsp_valid_q;
    logic [WIDTH-1:0] result_q;
    logic             carry_q;
    logic             ovf_q;
    logic             zero_q;
    logic             illegal_q;

    logic             is_sub;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] ex_result;
    logic             ex_carry;
    logic             ex_ovf;
    logic             ex_illegal;
    logic [KW-1:0]    step_amt;
    logic [WIDTH-1:0] sh_next;
    logic             req_is_iter_shift;

    assign bus.req_ready    = req_ready_q;
    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_result   = result_q;
    assign bus.rsp_carry    = carry_q;
    assign bus.rsp_overflow = ovf_q;
    assign bus.rsp_zero     = zero_q;
    assign bus.rsp_illegal  = illegal_q;

    assign req_is_iter_shift = (bus.req_select == OP_SLL || bus.req_select == OP_SRL) &&
                               (bus.req_b != '0) && (bus.req_b < WIDTH_V);

    always_comb begin
        is_sub     = (op_sel == OP_SUB);
        b_eff      = is_sub ? ~op_b : op_b;
        sum        = {1'b0, op_a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
        ex_result  = '0;
        ex_carry   = 1'b0;
        ex_ovf     = 1'b0;
        ex_illegal = 1'b0;
        case (op_sel)
            OP_ADD, OP_SUB: begin
                ex_result = sum[WIDTH-1:0];
                ex_carry  = sum[WIDTH];
                ex_ovf    = (op_a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != op_a[WIDTH-1]);
            end
            OP_AND:  ex_result = op_a & op_b;
            OP_OR:   ex_result = op_a | op_b;
            OP_XOR:  ex_result = op_a ^ op_b;
            // Only zero or out-of-range shift amounts reach EXEC.
            OP_SLL, OP_SRL: ex_result = (op_b == '0) ? op_a : '0;
            OP_SLT:  ex_result = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            OP_SLTU: ex_result = {{(WIDTH-1){1'b0}}, (op_a < op_b)};
            default: ex_illegal = 1'b1;
        endcase
        step_amt = (k < STEP_K) ? k : STEP_K;
        sh_next  = (op_sel == OP_SLL) ? (op_a << step_amt) : (op_a >> step_amt);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            op_a        <= '0;
            op_b        <= '0;
            op_sel      <= '0;
            k           <= '0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            busy        <= 1'b0;
            result_q    <= '0;
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid && req_ready_q) begin
                        op_a        <= bus.req_a;
                        op_b        <= bus.req_b;
                        op_sel      <= bus.req_select;
                        k           <= bus.req_b[KW-1:0];
                        req_ready_q <= 1'b0;
                        busy        <= 1'b1;
                        state       <= req_is_iter_shift ? SHIFT : EXEC;
                    end else begin
                        req_ready_q <= 1'b1;
                    end
                end
                EXEC: begin
                    result_q    <= ex_result;
                    carry_q     <= ex_carry;
                    ovf_q       <= ex_ovf;
                    zero_q      <= (ex_result == '0);
                    illegal_q   <= ex_illegal;
                    rsp_valid_q <= 1'b1;
                    state       <= RESP;
                end
                SHIFT: begin
                    op_a <= sh_next;
                    k    <= k - step_amt;
                    if (k == step_amt) begin
                        result_q    <= sh_next;
                        carry_q     <= 1'b0;
                        ovf_q       <= 1'b0;
                        zero_q      <= (sh_next == '0);
                        illegal_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        state       <= RESP;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_req_responder.sv
// Directed bench for alu_req_responder: an arithmetic reference model predicts
// result, flags and latency; a per-cycle compare process checks every response.
module tb_alu_req_responder;
    localparam int WIDTH = 32;
    localparam int STEP  = 1;
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    logic clk;
    logic rst_n;
    logic busy;

    alu_req_responder_if #(.WIDTH(WIDTH)) bus ();

    alu_req_responder #(.WIDTH(WIDTH), .SHIFT_STEP(STEP)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .busy  (busy)
    );

    typedef struct {
        logic [31:0] res;
        logic        c;
        logic        o;
        logic        z;
        logic        il;
        int          lat;
        int          acc_edge;
    } exp_t;

    typedef struct {
        logic [3:0]  sel;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        c;
        logic        o;
        logic        z;
        logic        il;
        int          lat;
    } vec_t;

    exp_t expq[$];
    vec_t vq[$];
    int   tests = 0;
    int   fails = 0;
    int   edge_cnt = 0;
    int   resp_count = 0;
    bit   prev_valid = 0;
    bit   seen = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic chkb(input string name, input logic act, input logic req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s actual=%b required=%b", name, act, req);
        end
    endtask

    function automatic exp_t model(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        longint      sa;
        longint      sb;
        longint      sr;
        logic [63:0] ua;
        logic [63:0] ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        sr = 0;
        e.res = 32'd0; e.c = 1'b0; e.o = 1'b0; e.il = 1'b0; e.lat = 1; e.acc_edge = 0;
        case (sel)
            4'b0000: begin
                e.res = a + b;
                e.c   = (ua + ub) > 64'h0000_0000_FFFF_FFFF;
                sr    = sa + sb;
                e.o   = (sr > SMAX) || (sr < SMIN);
            end
            4'b0001: begin
                e.res = a - b;
                e.c   = (a >= b);
                sr    = sa - sb;
                e.o   = (sr > SMAX) || (sr < SMIN);
            end
            4'b0010: e.res = a & b;
            4'b0100: e.res = a | b;
            4'b0110: e.res = a ^ b;
            4'b1000, 4'b1010: begin
                if (b >= 32) e.res = 32'd0;
                else e.res = (sel == 4'b1000) ? (a << b) : (a >> b);
                if (b != 0 && b < 32) e.lat = (int'(b) + STEP - 1) / STEP;
            end
            4'b1100: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b1110: e.res = (a < b) ? 32'd1 : 32'd0;
            default: e.il = 1'b1;
        endcase
        e.z = (e.res == 32'd0);
        return e;
    endfunction

    // Checks every cycle a response is presented; a response retires when valid falls.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (bus.rsp_valid) begin
                chkb("rsp_expected", expq.size() != 0, 1'b1);
                if (expq.size() != 0) begin
                    e = expq[0];
                    chk ("rsp_result",   bus.rsp_result,   e.res);
                    chkb("rsp_carry",    bus.rsp_carry,    e.c);
                    chkb("rsp_overflow", bus.rsp_overflow, e.o);
                    chkb("rsp_zero",     bus.rsp_zero,     e.z);
                    chkb("rsp_illegal",  bus.rsp_illegal,  e.il);
                    chkb("resp_req_ready", bus.req_ready,  1'b0);
                    chkb("resp_busy",    busy,             1'b1);
                    if (!seen) begin
                        chk("latency", 32'(edge_cnt - e.acc_edge), 32'(e.lat));
                        seen = 1'b1;
                    end
                end
            end else if (prev_valid) begin
                if (expq.size() != 0) void'(expq.pop_front());
                seen = 1'b0;
                resp_count++;
            end
            prev_valid = bus.rsp_valid;
        end else begin
            prev_valid = 1'b0;
            seen = 1'b0;
        end
    end

    task automatic add_vec(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] res, input logic c, input logic o,
                           input logic z, input logic il, input int lat);
        vec_t v;
        v.sel = sel; v.a = a; v.b = b; v.res = res;
        v.c = c; v.o = o; v.z = z; v.il = il; v.lat = lat;
        vq.push_back(v);
    endtask

    task automatic issue(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b, input exp_t e0);
        exp_t e;
        int   w;
        e = e0;
        w = 0;
        while (!bus.req_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        chkb("req_ready_wait", w < 100, 1'b1);
        bus.req_valid  = 1'b1;
        bus.req_a      = a;
        bus.req_b      = b;
        bus.req_select = sel;
        e.acc_edge     = edge_cnt + 1;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        expq.push_back(e);
    endtask

    task automatic wait_done();
        int w;
        w = 0;
        while (expq.size() != 0 && w < 400) begin
            @(negedge clk);
            w++;
        end
        chkb("rsp_wait", w < 400, 1'b1);
    endtask

    initial begin
        exp_t e;
        int   cnt0;
        int   w;
        rst_n = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.req_select = '0;
        bus.rsp_ready  = 1'b1;

        repeat (2) @(negedge clk);
        chkb("rst_req_ready", bus.req_ready, 1'b0);
        chkb("rst_rsp_valid", bus.rsp_valid, 1'b0);
        chkb("rst_busy",      busy,          1'b0);
        chk ("rst_result",    bus.rsp_result, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        chkb("req_ready_after_reset", bus.req_ready, 1'b1);

        //       sel      a             b             result        c     o     z     il   lat
        add_vec(4'b0000, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0, 1);
        add_vec(4'b0000, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1, 1'b0, 1'b0, 1);
        add_vec(4'b0001, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0, 1'b0, 1);
        add_vec(4'b0001, 32'h00000001, 32'h00000002, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 1);
        add_vec(4'b0001, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0, 1);
        add_vec(4'b0010, 32'h55555555, 32'hAAAAAAAA, 32'h00000000, 1'b0, 1'b0, 1'b1, 1'b0, 1);
        add_vec(4'b0100, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 1);
        add_vec(4'b0110, 32'h00000004, 32'h00000004, 32'h00000000, 1'b0, 1'b0, 1'b1, 1'b0, 1);
        add_vec(4'b1000, 32'h00000001, 32'h00000004, 32'h00000010, 1'b0, 1'b0, 1'b0, 1'b0, 4);
        add_vec(4'b1010, 32'h7FFFFFFF, 32'h0000001E, 32'h00000001, 1'b0, 1'b0, 1'b0, 1'b0, 30);
        add_vec(4'b1010, 32'h80000000, 32'h0000001F, 32'h00000001, 1'b0, 1'b0, 1'b0, 1'b0, 31);
        add_vec(4'b1000, 32'h00000001, 32'h00000020, 32'h00000000, 1'b0, 1'b0, 1'b1, 1'b0, 1);
        add_vec(4'b1000, 32'h00000001, 32'h00000021, 32'h00000000, 1'b0, 1'b0, 1'b1, 1'b0, 1);
        add_vec(4'b1000, 32'h0000ABCD, 32'h00000000, 32'h0000ABCD, 1'b0, 1'b0, 1'b0, 1'b0, 1);
        add_vec(4'b1100, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 1'b0, 1'b0, 1);
        add_vec(4'b1110, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1'b0, 1'b1, 1'b0, 1);
        add_vec(4'b1110, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0, 1'b0, 1);
        add_vec(4'b0011, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1'b0, 1'b0, 1'b1, 1'b1, 1);

        foreach (vq[i]) begin
            e = model(vq[i].sel, vq[i].a, vq[i].b);
            chk ("model_result",  e.res,      vq[i].res);
            chkb("model_carry",   e.c,        vq[i].c);
            chkb("model_ovf",     e.o,        vq[i].o);
            chkb("model_zero",    e.z,        vq[i].z);
            chkb("model_illegal", e.il,       vq[i].il);
            chk ("model_latency", 32'(e.lat), 32'(vq[i].lat));
            issue(vq[i].sel, vq[i].a, vq[i].b, e);
            wait_done();
            chk("held_result", bus.rsp_result, vq[i].res);
        end

        // Response stall with a competing request held on the bus.
        bus.rsp_ready = 1'b0;
        e = model(4'b0100, 32'hF0F0F0F0, 32'h0F0F0F0F);
        issue(4'b0100, 32'hF0F0F0F0, 32'h0F0F0F0F, e);
        w = 0;
        while (!bus.rsp_valid && w < 50) begin
            @(negedge clk);
            w++;
        end
        chkb("stall_valid_wait", w < 50, 1'b1);
        bus.req_valid  = 1'b1;
        bus.req_a      = 32'h00000123;
        bus.req_b      = 32'h00000005;
        bus.req_select = 4'b0000;
        repeat (5) begin
            @(negedge clk);
            chk ("stall_result",    bus.rsp_result, 32'hFFFFFFFF);
            chkb("stall_rsp_valid", bus.rsp_valid,  1'b1);
            chkb("stall_req_ready", bus.req_ready,  1'b0);
        end
        cnt0 = resp_count;
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        wait_done();
        chk ("stall_resp_count", 32'(resp_count), 32'(cnt0 + 1));
        chkb("stall_idle_busy",  busy, 1'b0);

        // Reset in the middle of a long shift discards the operation.
        e = model(4'b1010, 32'h7FFFFFFF, 32'h0000001E);
        issue(4'b1010, 32'h7FFFFFFF, 32'h0000001E, e);
        repeat (10) @(negedge clk);
        cnt0 = resp_count;
        rst_n = 1'b0;
        #1;
        chkb("midrst_rsp_valid", bus.rsp_valid, 1'b0);
        chkb("midrst_busy",      busy,          1'b0);
        chkb("midrst_req_ready", bus.req_ready, 1'b0);
        expq.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chkb("midrst_ready_after", bus.req_ready, 1'b1);
        repeat (40) @(negedge clk);
        chk ("midrst_no_stale", 32'(resp_count), 32'(cnt0));
        chkb("midrst_idle_valid", bus.rsp_valid, 1'b0);

        e = model(4'b0000, 32'h00000002, 32'h00000003);
        chk("model_add_small", e.res, 32'h00000005);
        issue(4'b0000, 32'h00000002, 32'h00000003, e);
        wait_done();
        chk("post_reset_result", bus.rsp_result, 32'h00000005);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
